// File: rtl/watchdog_array.sv
// watchdog_array: shared prescaler driving CHANNELS independent watchdog counters.
// Each channel has its own run enable, kick, sticky timeout, half-limit warning
// and timeout clear. Channels never interact; they share only limit and the tick.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   enable         per-channel run enable
//   kick           per-channel service pulse, restarts that counter
//   clear_timeout  per-channel clear of the sticky timeout (EXPIRED only)
//   limit          shared expiry limit in ticks
//   prescale       tick period minus one (0 = tick every cycle)
//   counter        flattened counters, channel i at [i*COUNTER_WIDTH +: COUNTER_WIDTH]
//   warning        counter >= limit/2 while RUNNING (combinational)
//   timeout        sticky expiry flag per channel (registered)
//   timeout_any    OR of timeout (combinational)
module watchdog_array #(
  parameter int unsigned CHANNELS       = 4,
  parameter int unsigned COUNTER_WIDTH  = 16,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic [CHANNELS-1:0]                  enable,
  input  logic [CHANNELS-1:0]                  kick,
  input  logic [CHANNELS-1:0]                  clear_timeout,
  input  logic [COUNTER_WIDTH-1:0]             limit,
  input  logic [PRESCALE_WIDTH-1:0]            prescale,
  output logic [CHANNELS*COUNTER_WIDTH-1:0]    counter,
  output logic [CHANNELS-1:0]                  warning,
  output logic [CHANNELS-1:0]                  timeout,
  output logic                                 timeout_any
);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_EXPIRED  = 2'd2
  } state_t;

  state_t                    state_q [CHANNELS];
  state_t                    state_d [CHANNELS];
  logic [COUNTER_WIDTH-1:0]  count_q [CHANNELS];
  logic [COUNTER_WIDTH-1:0]  count_d [CHANNELS];
  logic [CHANNELS-1:0]       timeout_q;
  logic [CHANNELS-1:0]       timeout_d;
  logic [PRESCALE_WIDTH-1:0] pcount_q;
  logic [PRESCALE_WIDTH-1:0] pcount_d;
  logic                      tick;
  logic [COUNTER_WIDTH-1:0]  half_limit;

  // Prescaler: >= compare so that lowering prescale below pcount wraps at once.
  always_comb begin
    tick     = (pcount_q >= prescale);
    pcount_d = tick ? '0 : pcount_q + PRESCALE_WIDTH'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pcount_q <= '0;
    end else begin
      pcount_q <= pcount_d;
    end
  end

  // Per-channel next state: disable beats kick, kick beats tick.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      state_d[i]   = state_q[i];
      count_d[i]   = count_q[i];
      timeout_d[i] = timeout_q[i];
      case (state_q[i])
        ST_DISABLED: begin
          count_d[i] = '0;
          if (enable[i]) begin
            state_d[i] = ST_RUNNING;
          end
        end
        ST_RUNNING: begin
          if (!enable[i]) begin
            state_d[i] = ST_DISABLED;
            count_d[i] = '0;
          end else if (kick[i]) begin
            count_d[i] = '0;
          end else if (tick && (count_q[i] >= limit)) begin
            // Counter holds its value so the expiry point stays observable.
            state_d[i]   = ST_EXPIRED;
            timeout_d[i] = 1'b1;
          end else if (tick) begin
            count_d[i] = count_q[i] + COUNTER_WIDTH'(1);
          end
        end
        ST_EXPIRED: begin
          if (clear_timeout[i]) begin
            timeout_d[i] = 1'b0;
            count_d[i]   = '0;
            state_d[i]   = enable[i] ? ST_RUNNING : ST_DISABLED;
          end
        end
        default: begin
          state_d[i]   = ST_DISABLED;
          count_d[i]   = '0;
          timeout_d[i] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= ST_DISABLED;
        count_q[i] <= '0;
      end
      timeout_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        state_q[i] <= state_d[i];
        count_q[i] <= count_d[i];
      end
      timeout_q <= timeout_d;
    end
  end

  // Warning tracks the live limit, so it reacts to limit changes without an edge.
  always_comb begin
    half_limit = limit >> 1;
    warning    = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      warning[i] = (state_q[i] == ST_RUNNING) && (count_q[i] >= half_limit);
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_counter
    assign counter[g*COUNTER_WIDTH +: COUNTER_WIDTH] = count_q[g];
  end

  assign timeout     = timeout_q;
  assign timeout_any = |timeout_q;

endmodule

// File: tb/tb_watchdog_array.sv
// Directed bench for watchdog_array: a 4-channel instance for the main behaviour
// and a 1-channel, 4-bit instance for the counter-ceiling case.
module tb_watchdog_array;

  logic        clock;
  logic        reset_n;
  logic [3:0]  enable;
  logic [3:0]  kick;
  logic [3:0]  clear_timeout;
  logic [15:0] limit;
  logic [7:0]  prescale;
  logic [63:0] counter;
  logic [3:0]  warning;
  logic [3:0]  timeout;
  logic        timeout_any;

  logic        s_reset_n;
  logic [0:0]  s_enable;
  logic [0:0]  s_kick;
  logic [0:0]  s_clear;
  logic [3:0]  s_limit;
  logic [7:0]  s_prescale;
  logic [3:0]  s_counter;
  logic [0:0]  s_warning;
  logic [0:0]  s_timeout;
  logic        s_timeout_any;

  int vectors = 0;
  int errors  = 0;

  watchdog_array #(.CHANNELS(4), .COUNTER_WIDTH(16), .PRESCALE_WIDTH(8)) u_dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .enable        (enable),
    .kick          (kick),
    .clear_timeout (clear_timeout),
    .limit         (limit),
    .prescale      (prescale),
    .counter       (counter),
    .warning       (warning),
    .timeout       (timeout),
    .timeout_any   (timeout_any)
  );

  watchdog_array #(.CHANNELS(1), .COUNTER_WIDTH(4), .PRESCALE_WIDTH(8)) u_small (
    .clock         (clock),
    .reset_n       (s_reset_n),
    .enable        (s_enable),
    .kick          (s_kick),
    .clear_timeout (s_clear),
    .limit         (s_limit),
    .prescale      (s_prescale),
    .counter       (s_counter),
    .warning       (s_warning),
    .timeout       (s_timeout),
    .timeout_any   (s_timeout_any)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [15:0] cnt(input int ch);
    return counter[ch*16 +: 16];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Reset held across one edge, released just after it: prescaler phase is 0.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n       = 1'b0;
    enable        = '0;
    kick          = '0;
    clear_timeout = '0;
    limit         = 16'd5;
    prescale      = 8'd0;
    s_reset_n     = 1'b0;
    s_enable      = 1'b0;
    s_kick        = 1'b0;
    s_clear       = 1'b0;
    s_limit       = 4'd15;
    s_prescale    = 8'd0;

    // Reset state
    step(2);
    chk("rst_counter", counter, 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_any", 64'(timeout_any), 64'd0);
    chk("rst_warning", 64'(warning), 64'd0);

    // 1: prescale 0, limit 5, channel 0 only
    enable = 4'b0001;
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      step(1);
      chk("t1_cnt0", 64'(cnt(0)), 64'(e - 1));
      chk("t1_warn0", 64'(warning[0]), 64'((e - 1) >= 2));
      chk("t1_to", 64'(timeout), 64'd0);
    end
    step(1);
    chk("t1_expire_to", 64'(timeout), 64'b0001);
    chk("t1_expire_any", 64'(timeout_any), 64'd1);
    chk("t1_expire_cnt0", 64'(cnt(0)), 64'd5);
    chk("t1_expire_warn", 64'(warning), 64'd0);
    chk("t1_others", 64'(counter[63:16]), 64'd0);

    // 2a: prescale 3, limit 2, channel 1; ticks land on edges 4, 8, 12
    enable   = 4'b0010;
    prescale = 8'd3;
    limit    = 16'd2;
    do_reset();
    step(3);
    chk("t2_e3", 64'(cnt(1)), 64'd0);
    step(1);
    chk("t2_e4", 64'(cnt(1)), 64'd1);
    step(3);
    chk("t2_e7", 64'(cnt(1)), 64'd1);
    step(1);
    chk("t2_e8", 64'(cnt(1)), 64'd2);
    step(3);
    chk("t2_e11_to", 64'(timeout), 64'd0);
    step(1);
    chk("t2_e12_to", 64'(timeout), 64'b0010);
    chk("t2_e12_cnt", 64'(cnt(1)), 64'd2);

    // 2b: kick on the tick cycle wins over the increment
    do_reset();
    step(7);
    chk("t2b_e7", 64'(cnt(1)), 64'd1);
    kick = 4'b0010;
    step(1);
    chk("t2b_kick", 64'(cnt(1)), 64'd0);
    kick = 4'b0000;
    step(4);
    chk("t2b_e12", 64'(cnt(1)), 64'd1);

    // 3: channel 2 expired, then frozen against kick/enable, then cleared
    enable   = 4'b0100;
    prescale = 8'd0;
    limit    = 16'd1;
    do_reset();
    step(3);
    chk("t3_to", 64'(timeout), 64'b0100);
    chk("t3_cnt", 64'(cnt(2)), 64'd1);
    kick   = 4'b0100;
    enable = 4'b0000;
    step(2);
    chk("t3_frozen_cnt", 64'(cnt(2)), 64'd1);
    chk("t3_frozen_to", 64'(timeout[2]), 64'd1);
    chk("t3_frozen_warn", 64'(warning[2]), 64'd0);
    kick          = 4'b0000;
    enable        = 4'b0100;
    clear_timeout = 4'b0100;
    step(1);
    clear_timeout = 4'b0000;
    chk("t3_clr_to", 64'(timeout), 64'd0);
    chk("t3_clr_cnt", 64'(cnt(2)), 64'd0);
    chk("t3_clr_warn", 64'(warning[2]), 64'd1);
    step(1);
    chk("t3_run_cnt", 64'(cnt(2)), 64'd1);

    // 4: limit lowered under two running counters expires both together
    enable = 4'b0011;
    limit  = 16'd100;
    do_reset();
    step(11);
    chk("t4_cnt0", 64'(cnt(0)), 64'd10);
    chk("t4_cnt1", 64'(cnt(1)), 64'd10);
    chk("t4_to_pre", 64'(timeout), 64'd0);
    limit = 16'd3;
    step(1);
    chk("t4_to", 64'(timeout), 64'b0011);
    chk("t4_any", 64'(timeout_any), 64'd1);
    chk("t4_hold0", 64'(cnt(0)), 64'd10);

    // 5: asynchronous reset with ch0 expired and ch3 at 40
    enable = 4'b0001;
    limit  = 16'd10;
    do_reset();
    step(12);
    chk("t5_ch0_to", 64'(timeout), 64'b0001);
    limit  = 16'd100;
    enable = 4'b1001;
    step(41);
    chk("t5_cnt3", 64'(cnt(3)), 64'd40);
    chk("t5_to_held", 64'(timeout), 64'b0001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_async_cnt", counter, 64'd0);
    chk("t5_async_to", 64'(timeout), 64'd0);
    chk("t5_async_any", 64'(timeout_any), 64'd0);
    chk("t5_async_warn", 64'(warning), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    step(1);
    chk("t5_restart0", 64'(cnt(3)), 64'd0);
    step(1);
    chk("t5_restart1", 64'(cnt(3)), 64'd1);

    // 6: 4-bit counter reaches 15 without wrapping, expires on 16th tick edge
    s_enable = 1'b1;
    @(posedge clock);
    #1;
    s_reset_n = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      step(1);
      chk("t6_cnt", 64'(s_counter), 64'(e - 1));
    end
    chk("t6_to_pre", 64'(s_timeout), 64'd0);
    step(1);
    chk("t6_to", 64'(s_timeout), 64'd1);
    chk("t6_any", 64'(s_timeout_any), 64'd1);
    chk("t6_cnt_hold", 64'(s_counter), 64'd15);
    step(1);
    chk("t6_frozen", 64'(s_counter), 64'd15);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
